muldiv_unit: RTL

- Iterative RV32M multiply/divide execution unit sitting directly downstream of the register file.
- Consumes the two read-port operands (RD1, RD2) alongside the ALU and produces a write-back result, destination register index and write-enable that feed the register file write port (WD3, AD3, WE3).
- Radix-2 with fixed latency: one bit per clock, start/busy/done handshake.
- The surrounding control stalls while busy is high.

---
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake and operand/result bus between the issue stage and muldiv_unit.
interface muldiv_unit_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5
);
   logic                     start;
   logic [2:0]               op;
   logic [DATA_WIDTH-1:0]    src_a;
   logic [DATA_WIDTH-1:0]    src_b;
   logic [ADDRESS_WIDTH-1:0] rd_in;
   logic                     abort;
   logic                     busy;
   logic                     done;
   logic [DATA_WIDTH-1:0]    result;
   logic [ADDRESS_WIDTH-1:0] rd_out;

   modport master (
      output start, op, src_a, src_b, rd_in, abort,
      input  busy, done, result, rd_out
   );

   modport slave (
      input  start, op, src_a, src_b, rd_in, abort,
      output busy, done, result, rd_out
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2, one bit per clock,
// fixed 33-cycle latency from accepted start to the done pulse.
module muldiv_unit #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5
) (
   input logic          clk,
   input logic          rst_n,
   muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIXUP, ST_DONE} state_t;

   state_t                   state;
   logic [CW-1:0]            cnt;
   logic [2:0]               op_q;
   logic [ADDRESS_WIDTH-1:0] rd_q;
   logic [DATA_WIDTH-1:0]    acc_hi;
   logic [DATA_WIDTH-1:0]    acc_lo;
   logic [DATA_WIDTH-1:0]    mag_b;
   logic                     neg_pq;
   logic                     neg_r;
   logic                     div_zero;
   logic                     busy_q;
   logic                     done_q;
   logic [DATA_WIDTH-1:0]    result_q;
   logic [ADDRESS_WIDTH-1:0] rd_out_q;

   logic                     sa;
   logic                     sb;
   logic [DATA_WIDTH-1:0]    start_mag_a;
   logic [DATA_WIDTH-1:0]    start_mag_b;
   logic [DATA_WIDTH:0]      mul_sum;
   logic [2*DATA_WIDTH-1:0]  mul_next;
   logic [DATA_WIDTH:0]      div_shift;
   logic                     div_ge;
   logic [DATA_WIDTH-1:0]    div_diff;
   logic [2*DATA_WIDTH-1:0]  div_next;
   logic [2*DATA_WIDTH-1:0]  prod_fix;
   logic [DATA_WIDTH-1:0]    quot_fix;
   logic [DATA_WIDTH-1:0]    rem_fix;
   logic [DATA_WIDTH-1:0]    fix_result;

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.rd_out = rd_out_q;

   // Operand sign/magnitude capture, one shift-add / restoring-divide step, and sign fixup.
   always_comb begin
      sa = 1'b0;
      sb = 1'b0;
      if (bus.op[2]) begin
         sa = ~bus.op[0] & bus.src_a[DATA_WIDTH-1];
         sb = ~bus.op[0] & bus.src_b[DATA_WIDTH-1];
      end else begin
         sa = (bus.op[1:0] != 2'b11) & bus.src_a[DATA_WIDTH-1];
         sb = ~bus.op[1] & bus.src_b[DATA_WIDTH-1];
      end
      start_mag_a = sa ? -bus.src_a : bus.src_a;
      start_mag_b = sb ? -bus.src_b : bus.src_b;

      // multiplier sits in acc_lo and is consumed LSB first
      mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
      mul_next = {mul_sum, acc_lo[DATA_WIDTH-1:1]};

      // acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in
      div_shift = {acc_hi, acc_lo[DATA_WIDTH-1]};
      div_ge    = div_shift >= {1'b0, mag_b};
      div_diff  = div_shift[DATA_WIDTH-1:0] - mag_b;
      div_next  = {(div_ge ? div_diff : div_shift[DATA_WIDTH-1:0]),
                   acc_lo[DATA_WIDTH-2:0], div_ge};

      prod_fix = neg_pq ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
      quot_fix = neg_pq ? -acc_lo : acc_lo;
      rem_fix  = neg_r  ? -acc_hi : acc_hi;

      fix_result = '0;
      case (op_q)
         3'b000:                 fix_result = prod_fix[DATA_WIDTH-1:0];
         3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
         3'b100, 3'b101:         fix_result = div_zero ? '1 : quot_fix;
         default:                fix_result = rem_fix;
      endcase
   end

   // Control FSM with datapath registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         op_q     <= '0;
         rd_q     <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         mag_b    <= '0;
         neg_pq   <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         rd_out_q <= '0;
      end else if (bus.abort) begin
         state  <= ST_IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  op_q     <= bus.op;
                  rd_q     <= bus.rd_in;
                  acc_hi   <= '0;
                  acc_lo   <= start_mag_a;
                  mag_b    <= start_mag_b;
                  neg_pq   <= sa ^ sb;
                  neg_r    <= sa;
                  div_zero <= (bus.src_b == '0);
                  cnt      <= '0;
                  busy_q   <= 1'b1;
                  state    <= ST_CALC;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_CALC: begin
               {acc_hi, acc_lo} <= op_q[2] ? div_next : mul_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) state <= ST_FIXUP;
            end
            ST_FIXUP: begin
               result_q <= fix_result;
               rd_out_q <= rd_q;
               busy_q   <= 1'b0;
               done_q   <= 1'b1;
               state    <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
